keypad_scanner: RTL and testbench

- Scans the 4x4 hex keypad matrix, synchronises and debounces every key, and presents a stable 16-bit level vector.
- Sits directly upstream of the CPU: `keys` connects straight to the CPU's `keys[15:0]` input.
- Bit i of `keys` is 1 while CHIP-8 key value i is held. The CPU uses it for Ex9E/ExA1/Fx0A.

---
 rtl/keypad_scanner_pkg.sv | 28 ++
 rtl/keypad_debounce.sv | 50 +++++
 rtl/keypad_scanner.sv | 112 +++++++++++
 tb/tb_keypad_scanner.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/keypad_scanner_pkg.sv
// Shared constants for the 4x4 hex keypad scanner: the matrix-position to
// CHIP-8 key-value map, the idle column drive pattern and a priority helper.
package keypad_scanner_pkg;

  // All columns released (active-low drive).
  localparam logic [3:0] COL_IDLE = 4'hF;

  // Key value at matrix position p = row*4 + col, packed LSB-first
  // (nibble p holds the key value).
  //   r0: 1 2 3 C   r1: 4 5 6 D   r2: 7 8 9 E   r3: A 0 B F
  localparam logic [63:0] KEY_MAP = {
    4'hF, 4'hB, 4'h0, 4'hA,
    4'hE, 4'h9, 4'h8, 4'h7,
    4'hD, 4'h6, 4'h5, 4'h4,
    4'hC, 4'h3, 4'h2, 4'h1
  };

  // Index of the lowest set bit; 0 when no bit is set.
  function automatic logic [3:0] lowest_set(input logic [15:0] v);
    logic [3:0] res;
    res = 4'h0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) res = 4'(i);
    end
    return res;
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Debounce state for one key: the level flips only after DEBOUNCE
// consecutive samples that disagree with it. Samples arrive once per scan.
module keypad_debounce
  import keypad_scanner_pkg::*;
#(
  parameter int DEBOUNCE = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic sample_en,
  input  logic raw,
  output logic level
);

  // One extra bit so the counter can reach DEBOUNCE-1 without wrapping.
  localparam int CW = $clog2(DEBOUNCE) + 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;

  // Next-state: clear on agreement, toggle after enough disagreements.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (sample_en) begin
      if (raw == level_q) begin
        cnt_d = '0;
      end else if (cnt_q == CW'(DEBOUNCE - 1)) begin
        level_d = ~level_q;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level = level_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 hex keypad scanner: drives one active-low column at a time, syncs the
// row inputs, debounces all 16 keys and outputs their levels by key value.
// Optional press-event output enabled with macro KEYPAD_EVENT_EN.
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic [3:0]  cols,
  input  logic [3:0]  rows,
  output logic [15:0] keys,
  output logic        key_press,
  output logic [3:0]  key_code
);

  localparam int DW = $clog2(SCAN_DIV);

  logic [DW-1:0] dwell_q, dwell_d;
  logic [1:0]    col_q, col_d;
  logic [3:0]    cols_q, cols_d;
  logic [3:0]    rows_meta_q, rows_sync_q;
  logic          last_dwell;
  logic [15:0]   mat_level;
  logic [15:0]   keys_w;

  // Rows are sampled for the current column on the last dwell cycle.
  assign last_dwell = (dwell_q == DW'(SCAN_DIV - 1));

  // Scan next-state: advance column after the sample cycle.
  always_comb begin
    dwell_d = dwell_q + DW'(1);
    col_d   = col_q;
    cols_d  = cols_q;
    if (last_dwell) begin
      dwell_d = '0;
      col_d   = col_q + 2'd1;
      cols_d  = COL_IDLE ^ (4'b0001 << col_d);
    end
  end

  // Scan counters, column drive and the two-flop row synchroniser.
  always_ff @(posedge clk) begin
    if (reset) begin
      dwell_q     <= '0;
      col_q       <= 2'd0;
      cols_q      <= 4'b1110;
      rows_meta_q <= 4'hF;
      rows_sync_q <= 4'hF;
    end else begin
      dwell_q     <= dwell_d;
      col_q       <= col_d;
      cols_q      <= cols_d;
      rows_meta_q <= rows;
      rows_sync_q <= rows_meta_q;
    end
  end

  assign cols = cols_q;

  // One debouncer per matrix position, routed to its key-value bit.
  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_key
      localparam int         ROW = gi / 4;
      localparam int         COL = gi % 4;
      localparam logic [3:0] KID = KEY_MAP[gi*4 +: 4];

      keypad_debounce #(
        .DEBOUNCE (DEBOUNCE)
      ) u_db (
        .clk       (clk),
        .reset     (reset),
        .sample_en (last_dwell && (col_q == 2'(COL))),
        .raw       (~rows_sync_q[ROW]),
        .level     (mat_level[gi])
      );

      assign keys_w[KID] = mat_level[gi];
    end
  endgenerate

  assign keys = keys_w;

`ifdef KEYPAD_EVENT_EN
  logic [15:0] keys_prev_q;
  logic [15:0] rise;
  logic [3:0]  code_q;

  // Keys that went 0->1 on the previous clock edge (the sample edge).
  assign rise = keys_w & ~keys_prev_q;

  // Remember last levels and the last reported key code.
  always_ff @(posedge clk) begin
    if (reset) begin
      keys_prev_q <= 16'h0000;
      code_q      <= 4'h0;
    end else begin
      keys_prev_q <= keys_w;
      code_q      <= key_code;
    end
  end

  assign key_press = |rise;
  assign key_code  = (|rise) ? lowest_set(rise) : code_q;
`else
  assign key_press = 1'b0;
  assign key_code  = 4'h0;
`endif

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE=3. A behavioural
// keypad drives rows from cols; expected key vectors go through a queue.
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DEBOUNCE = 3;
  localparam int TB_MAP[16] = '{1, 2, 3, 12, 4, 5, 6, 13, 7, 8, 9, 14, 10, 0, 11, 15};

`ifdef KEYPAD_EVENT_EN
  localparam int         EXP_PULSES = 1;
  localparam logic [3:0] EXP_CODE   = 4'h6;
`else
  localparam int         EXP_PULSES = 0;
  localparam logic [3:0] EXP_CODE   = 4'h0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  cols;
  logic [3:0]  rows;
  logic [15:0] keys;
  logic        key_press;
  logic [3:0]  key_code;
  logic [15:0] pressed = 16'h0000;

  logic [15:0] exp_q[$];
  logic [3:0]  col_exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  keypad_scanner #(
    .SCAN_DIV (SCAN_DIV),
    .DEBOUNCE (DEBOUNCE)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cols      (cols),
    .rows      (rows),
    .keys      (keys),
    .key_press (key_press),
    .key_code  (key_code)
  );

  always #5 clk = ~clk;

  // Matrix model: a held key pulls its row low while its column is driven.
  always_comb begin
    rows = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[TB_MAP[r*4+c]] && (cols[c] == 1'b0)) rows[r] = 1'b0;
      end
    end
  end

  // Wait on negedges until keys changes, up to budget cycles.
  task automatic wait_change(input int budget, output int elapsed, output bit timed_out);
    logic [15:0] start;
    start     = keys;
    timed_out = 1'b1;
    elapsed   = 0;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (keys !== start) begin
        elapsed   = i;
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset;
    logic [3:0] e, got;
    reset   = 1'b1;
    pressed = 16'h0000;
    repeat (3) @(negedge clk);
    n_cmp++; if (cols !== 4'b1110) begin n_bad++; $display("FAIL reset_cols got=%b exp=1110", cols); end
    n_cmp++; if (keys !== 16'h0000) begin n_bad++; $display("FAIL reset_keys got=%h exp=0000", keys); end
    n_cmp++; if (key_press !== 1'b0) begin n_bad++; $display("FAIL reset_key_press got=%b exp=0", key_press); end
    n_cmp++; if (key_code !== 4'h0) begin n_bad++; $display("FAIL reset_key_code got=%h exp=0", key_code); end
    $display("reset: cols=%b keys=%h", cols, keys);
    reset = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      e = 4'hF ^ (4'b0001 << ((k / 4) % 4));
      col_exp_q.push_back(e);
      @(negedge clk);
      got = cols;
      e   = col_exp_q.pop_front();
      n_cmp++; if (got !== e) begin n_bad++; $display("FAIL scan_cols cycle=%0d got=%b exp=%b", k, got, e); end
    end
    $display("scan: 17 column steps checked");
  endtask

  task automatic test_press_release;
    int elapsed; bit to; logic [15:0] e;
    for (int ph = 0; ph < 2; ph++) begin
      pressed[5] = (ph == 0);
      exp_q.push_back((ph == 0) ? 16'h0020 : 16'h0000);
      wait_change(60, elapsed, to);
      e = exp_q.pop_front();
      n_cmp++; if (to) begin n_bad++; $display("FAIL key5_timeout phase=%0d got=%h exp=%h", ph, keys, e); end
      n_cmp++; if (keys !== e) begin n_bad++; $display("FAIL key5_value phase=%0d got=%h exp=%h", ph, keys, e); end
      n_cmp++; if (elapsed < 35 || elapsed > 51) begin n_bad++; $display("FAIL key5_latency phase=%0d got=%0d exp=35..51", ph, elapsed); end
      $display("key5 phase=%0d keys=%h latency=%0d", ph, keys, elapsed);
    end
  endtask

  task automatic test_bounce;
    int dur[4] = '{32, 24, 32, 60};
    int glitches; logic [15:0] e;
    glitches = 0;
    exp_q.push_back(16'h0000);
    for (int p = 0; p < 4; p++) begin
      pressed[5] = (p % 2 == 0);
      for (int n = 0; n < dur[p]; n++) begin
        @(negedge clk);
        if (keys !== 16'h0000) glitches++;
      end
    end
    e = exp_q.pop_front();
    n_cmp++; if (glitches != 0) begin n_bad++; $display("FAIL bounce_glitches got=%0d exp=0", glitches); end
    n_cmp++; if (keys !== e) begin n_bad++; $display("FAIL bounce_keys got=%h exp=%h", keys, e); end
    $display("bounce: keys=%h nonzero_cycles=%0d", keys, glitches);
  endtask

  task automatic test_simultaneous;
    int elapsed; bit to; logic [15:0] e, part;
    for (int ph = 0; ph < 2; ph++) begin
      pressed = (ph == 0) ? 16'h8492 : 16'h0000;
      exp_q.push_back(pressed);
      for (int ch = 0; ch < 2; ch++) begin
        wait_change(60, elapsed, to);
        n_cmp++; if (to) begin n_bad++; $display("FAIL simul_timeout phase=%0d got=%h exp=%h", ph, keys, pressed); end
        if (to) break;
        part = keys & 16'h0492;
        n_cmp++; if (part !== 16'h0000 && part !== 16'h0492) begin n_bad++; $display("FAIL simul_col0_split phase=%0d got=%h exp=0000_or_0492", ph, part); end
        $display("simul phase=%0d change=%0d keys=%h", ph, ch, keys);
        if (keys === pressed) break;
      end
      e = exp_q.pop_front();
      n_cmp++; if (keys !== e) begin n_bad++; $display("FAIL simul_final phase=%0d got=%h exp=%h", ph, keys, e); end
    end
  endtask

  task automatic test_reset_mid_dwell;
    int elapsed; bit to; logic [15:0] e;
    for (int i = 0; i < 20 && cols === 4'b1101; i++) @(negedge clk);
    for (int i = 0; i < 20 && cols !== 4'b1101; i++) @(negedge clk);
    pressed[5] = 1'b1;
    repeat (21) @(negedge clk);
    n_cmp++; if (keys !== 16'h0000) begin n_bad++; $display("FAIL mid_pre_reset got=%h exp=0000", keys); end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (keys !== 16'h0000) begin n_bad++; $display("FAIL mid_reset_keys got=%h exp=0000", keys); end
    n_cmp++; if (cols !== 4'b1110) begin n_bad++; $display("FAIL mid_reset_cols got=%b exp=1110", cols); end
    reset = 1'b0;
    exp_q.push_back(16'h0020);
    wait_change(60, elapsed, to);
    e = exp_q.pop_front();
    n_cmp++; if (to) begin n_bad++; $display("FAIL mid_timeout got=%h exp=%h", keys, e); end
    n_cmp++; if (keys !== e) begin n_bad++; $display("FAIL mid_value got=%h exp=%h", keys, e); end
    n_cmp++; if (elapsed != 40) begin n_bad++; $display("FAIL mid_latency got=%0d exp=40", elapsed); end
    $display("reset_mid_dwell: keys=%h latency=%0d", keys, elapsed);
    pressed[5] = 1'b0;
    exp_q.push_back(16'h0000);
    wait_change(60, elapsed, to);
    e = exp_q.pop_front();
    n_cmp++; if (keys !== e) begin n_bad++; $display("FAIL mid_release got=%h exp=%h", keys, e); end
  endtask

  task automatic test_event;
    int pulses; logic [3:0] code_at_pulse; logic [15:0] e;
    for (int ph = 0; ph < 2; ph++) begin
      pressed = (ph == 0) ? 16'h0240 : 16'h0000;
      exp_q.push_back(pressed);
      pulses        = 0;
      code_at_pulse = 4'h0;
      for (int n = 0; n < 70; n++) begin
        @(negedge clk);
        if (key_press === 1'b1) begin
          pulses++;
          code_at_pulse = key_code;
        end
      end
      e = exp_q.pop_front();
      n_cmp++; if (keys !== e) begin n_bad++; $display("FAIL event_keys phase=%0d got=%h exp=%h", ph, keys, e); end
      n_cmp++; if (pulses != ((ph == 0) ? EXP_PULSES : 0)) begin n_bad++; $display("FAIL event_pulses phase=%0d got=%0d exp=%0d", ph, pulses, (ph == 0) ? EXP_PULSES : 0); end
      if (pulses > 0) begin
        n_cmp++; if (code_at_pulse !== EXP_CODE) begin n_bad++; $display("FAIL event_code phase=%0d got=%h exp=%h", ph, code_at_pulse, EXP_CODE); end
      end
      n_cmp++; if (key_code !== EXP_CODE) begin n_bad++; $display("FAIL event_code_hold phase=%0d got=%h exp=%h", ph, key_code, EXP_CODE); end
      $display("event phase=%0d keys=%h pulses=%0d key_code=%h", ph, keys, pulses, key_code);
    end
  endtask

  initial begin
    test_reset();
    test_press_release();
    test_bounce();
    test_simultaneous();
    test_reset_mid_dwell();
    test_event();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached compared=%0d mismatched=%0d", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

endmodule
